// File: rtl/lfu_pkg.sv
// rtl/lfu_pkg.sv - shared types and constants for the LFU counter bank
package lfu_pkg;
    localparam int NUM_WAYS = 4;
    localparam int SIZE_COUNTER_DEF = 4;

    typedef logic [1:0] way_t;
    typedef enum logic {IDLE, SWEEP} lfu_state_t;
endpackage

// File: rtl/lfu_set_update.sv
// rtl/lfu_set_update.sv - combinational next value of one set's four LFU counters
module lfu_set_update
    import lfu_pkg::*;
#(
    parameter int SIZE_COUNTER = SIZE_COUNTER_DEF
) (
    input  logic [NUM_WAYS-1:0][SIZE_COUNTER-1:0] cur_cnt,
    input  logic                                  hit,
    input  logic                                  fill,
    input  way_t                                  way,
    input  logic                                  halve,
    input  logic                                  clear,
    output logic [NUM_WAYS-1:0][SIZE_COUNTER-1:0] nxt_cnt
);
    localparam logic [SIZE_COUNTER-1:0] CMAX = {SIZE_COUNTER{1'b1}};

    logic [NUM_WAYS-1:0][SIZE_COUNTER-1:0] base_cnt;

    always_comb begin
        base_cnt = cur_cnt;
        if (halve) begin
            for (int w = 0; w < NUM_WAYS; w++) base_cnt[w] = cur_cnt[w] >> 1;
        end
        nxt_cnt = base_cnt;
        if (clear) begin
            nxt_cnt = '0;
        end else if (hit) begin
            // A saturated way rescales the whole set so relative order survives
            if (base_cnt[way] == CMAX) begin
                for (int w = 0; w < NUM_WAYS; w++) nxt_cnt[w] = base_cnt[w] >> 1;
                nxt_cnt[way] = (base_cnt[way] >> 1) + SIZE_COUNTER'(1);
            end else begin
                nxt_cnt[way] = base_cnt[way] + SIZE_COUNTER'(1);
            end
        end else if (fill) begin
            nxt_cnt[way] = SIZE_COUNTER'(1);
        end
    end
endmodule

// File: rtl/lfu_counter_bank.sv
// rtl/lfu_counter_bank.sv - per-set 4-way LFU use counters with hit/fill/invalidate updates
// Optional periodic decay sweep enabled by LFU_DECAY_EN.
module lfu_counter_bank
    import lfu_pkg::*;
#(
    parameter int SIZE_COUNTER = 4,
    parameter int NUM_SETS     = 16,
    parameter int DECAY_PERIOD = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    input  logic [$clog2(NUM_SETS)-1:0] acc_set,
    input  logic [1:0]                  acc_way,
    input  logic                        acc_hit,
    input  logic                        inv_valid,
    input  logic [$clog2(NUM_SETS)-1:0] inv_set,
    input  logic [$clog2(NUM_SETS)-1:0] rd_set,
    output logic [SIZE_COUNTER-1:0]     count0,
    output logic [SIZE_COUNTER-1:0]     count1,
    output logic [SIZE_COUNTER-1:0]     count2,
    output logic [SIZE_COUNTER-1:0]     count3
);
    localparam int SW = $clog2(NUM_SETS);

    if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0 || DECAY_PERIOD < 1) begin : g_bad_param
        $error("lfu_counter_bank: invalid NUM_SETS or DECAY_PERIOD");
    end

    logic [NUM_SETS-1:0][NUM_WAYS-1:0][SIZE_COUNTER-1:0] cnt_q, cnt_d;
    logic [NUM_WAYS-1:0][SIZE_COUNTER-1:0]               count_q, count_d;
    logic [NUM_WAYS-1:0][SIZE_COUNTER-1:0]               upd_nxt;
    logic                                                sweeping;
    logic [SW-1:0]                                       sweep_idx;
    logic [SW-1:0]                                       upd_set;
    logic                                                accept;
    logic                                                upd_en;

`ifdef LFU_DECAY_EN
    localparam int TW = $clog2(DECAY_PERIOD + 1);

    lfu_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] sweep_idx_q, sweep_idx_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            IDLE: begin
                if (timer_q == TW'(DECAY_PERIOD - 1)) begin
                    state_d = SWEEP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SWEEP: begin
                if (sweep_idx_q == SW'(NUM_SETS - 1)) begin
                    state_d     = IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    assign sweeping  = (state_q == SWEEP);
    assign sweep_idx = sweep_idx_q;
    assign acc_ready = (state_q == IDLE);
`else
    assign sweeping  = 1'b0;
    assign sweep_idx = '0;
    assign acc_ready = 1'b1;
`endif

    // Accesses are blocked while sweeping, so one update path serves both
    assign accept  = acc_valid & acc_ready;
    assign upd_en  = accept | sweeping;
    assign upd_set = sweeping ? sweep_idx : acc_set;

    lfu_set_update #(
        .SIZE_COUNTER(SIZE_COUNTER)
    ) u_set_update (
        .cur_cnt (cnt_q[upd_set]),
        .hit     (accept & acc_hit),
        .fill    (accept & ~acc_hit),
        .way     (acc_way),
        .halve   (sweeping),
        .clear   (inv_valid && (inv_set == upd_set)),
        .nxt_cnt (upd_nxt)
    );

    always_comb begin
        cnt_d   = cnt_q;
        count_d = cnt_q[rd_set];
        for (int s = 0; s < NUM_SETS; s++) begin
            if (inv_valid && (inv_set == SW'(s))) begin
                cnt_d[s] = '0;
            end else if (upd_en && (upd_set == SW'(s))) begin
                cnt_d[s] = upd_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign count0 = count_q[0];
    assign count1 = count_q[1];
    assign count2 = count_q[2];
    assign count3 = count_q[3];
endmodule

// File: tb/tb_lfu_counter_bank.sv
// tb/tb_lfu_counter_bank.sv - scoreboard bench for lfu_counter_bank against a behavioural model
module tb_lfu_counter_bank;
    localparam int SC = 4;
`ifdef LFU_DECAY_EN
    localparam int NS = 4;
    localparam int DP = 8;
`else
    localparam int NS = 16;
    localparam int DP = 1024;
`endif
    localparam int SWB  = $clog2(NS);
    localparam int CMAX = (1 << SC) - 1;

    logic           clk;
    logic           rst_n;
    logic           acc_valid;
    logic           acc_ready;
    logic [SWB-1:0] acc_set;
    logic [1:0]     acc_way;
    logic           acc_hit;
    logic           inv_valid;
    logic [SWB-1:0] inv_set;
    logic [SWB-1:0] rd_set;
    logic [SC-1:0]  count0, count1, count2, count3;

    lfu_counter_bank #(
        .SIZE_COUNTER(SC),
        .NUM_SETS    (NS),
        .DECAY_PERIOD(DP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .acc_valid(acc_valid),
        .acc_ready(acc_ready),
        .acc_set  (acc_set),
        .acc_way  (acc_way),
        .acc_hit  (acc_hit),
        .inv_valid(inv_valid),
        .inv_set  (inv_set),
        .rd_set   (rd_set),
        .count0   (count0),
        .count1   (count1),
        .count2   (count2),
        .count3   (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][SC-1:0] c;
        logic               rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mcnt[NS][4];
    bit   m_ready;
    bit   m_sweep;
    int   m_timer;
    int   m_idx;

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < 4; w++) mcnt[s][w] = 0;
        m_ready = 1'b1;
        m_sweep = 1'b0;
        m_timer = 0;
        m_idx   = 0;
    endfunction

    // One clock edge of the reference behaviour, using the inputs currently driven
    function automatic void model_edge();
        bit acc = acc_valid && m_ready;
        int s   = int'(acc_set);
        int w   = int'(acc_way);
        if (acc) begin
            if (!acc_hit) mcnt[s][w] = 1;
            else if (mcnt[s][w] == CMAX) begin
                for (int k = 0; k < 4; k++) mcnt[s][k] = mcnt[s][k] / 2;
                mcnt[s][w] = mcnt[s][w] + 1;
            end else mcnt[s][w] = mcnt[s][w] + 1;
        end
`ifdef LFU_DECAY_EN
        if (m_sweep) begin
            for (int k = 0; k < 4; k++) mcnt[m_idx][k] = mcnt[m_idx][k] / 2;
            if (m_idx == NS - 1) begin
                m_sweep = 1'b0;
                m_idx   = 0;
            end else m_idx = m_idx + 1;
        end else if (m_timer == DP - 1) begin
            m_sweep = 1'b1;
            m_timer = 0;
        end else m_timer = m_timer + 1;
        m_ready = !m_sweep;
`endif
        if (inv_valid)
            for (int k = 0; k < 4; k++) mcnt[int'(inv_set)][k] = 0;
    endfunction

    task automatic drive(bit av, int s, int w, bit h, bit iv, int is, int rs);
        exp_t e;
        acc_valid = av;
        acc_set   = SWB'(s);
        acc_way   = 2'(w);
        acc_hit   = h;
        inv_valid = iv;
        inv_set   = SWB'(is);
        rd_set    = SWB'(rs);
        for (int k = 0; k < 4; k++) e.c[k] = SC'(mcnt[rs][k]);
        model_edge();
        e.rdy = m_ready;
        q.push_back(e);
    endtask

    task automatic cycle(bit av, int s, int w, bit h, bit iv, int is, int rs);
        @(negedge clk);
        drive(av, s, w, h, iv, is, rs);
    endtask

    // Monitor: outputs after each edge must match what was queued for that edge
    always begin
        @(posedge clk);
        #1;
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("count0", int'(count0), int'(e.c[0]));
            check("count1", int'(count1), int'(e.c[1]));
            check("count2", int'(count2), int'(e.c[2]));
            check("count3", int'(count3), int'(e.c[3]));
            check("acc_ready", int'(acc_ready), int'(e.rdy));
        end
    end

    task automatic load(int s, int w, int v);
        cycle(1, s, w, 0, 0, 0, s);
        for (int i = 1; i < v; i++) cycle(1, s, w, 1, 0, 0, s);
    endtask

    task automatic check_set(int s, int e0, int e1, int e2, int e3);
        cycle(0, 0, 0, 0, 0, 0, s);
        @(posedge clk);
        #2;
        check($sformatf("set%0d.w0", s), int'(count0), e0);
        check($sformatf("set%0d.w1", s), int'(count1), e1);
        check($sformatf("set%0d.w2", s), int'(count2), e2);
        check($sformatf("set%0d.w3", s), int'(count3), e3);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        acc_valid = 1'b0;
        inv_valid = 1'b0;
        #1;
        check("rst.count0", int'(count0), 0);
        check("rst.count1", int'(count1), 0);
        check("rst.count2", int'(count2), 0);
        check("rst.count3", int'(count3), 0);
        check("rst.acc_ready", int'(acc_ready), 1);
        q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        acc_valid = 1'b0;
        acc_set   = '0;
        acc_way   = '0;
        acc_hit   = 1'b0;
        inv_valid = 1'b0;
        inv_set   = '0;
        rd_set    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

`ifndef LFU_DECAY_EN
        for (int i = 0; i < 5; i++) cycle(1, 3, 2, 1, 0, 0, 3);
        check_set(3, 0, 0, 5, 0);

        cycle(0, 0, 0, 0, 1, 1, 1);
        load(1, 0, 15);
        load(1, 1, 4);
        load(1, 2, 7);
        load(1, 3, 1);
        check_set(1, 15, 4, 7, 1);
        cycle(1, 1, 0, 1, 0, 0, 1);
        check_set(1, 8, 2, 3, 0);
        cycle(1, 1, 3, 0, 0, 0, 1);
        check_set(1, 8, 2, 3, 1);
        cycle(1, 1, 0, 0, 0, 0, 1);
        check_set(1, 1, 2, 3, 1);

        load(5, 1, 3);
        cycle(1, 5, 1, 1, 1, 5, 5);
        check_set(5, 0, 0, 0, 0);
        load(5, 1, 3);
        load(6, 0, 2);
        cycle(1, 5, 1, 1, 1, 6, 5);
        check_set(5, 0, 4, 0, 0);
        check_set(6, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 2000; i++) begin
            int s, rs;
            s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(0, 3) % NS);
            rs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, NS - 1)) : s;
            cycle($urandom_range(0, 1), s, $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, NS - 1), rs);
            if (i == 1000) async_reset();
        end

        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
